spi_master_gen2: RTL and testbench

//  Parametrised, synthesizable SPI master; next generation of the team's 8-bit SPI master.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_clk_gen.sv | 36 +++
 rtl/spi_master_gen2.sv | 178 +++++++++++++++++
 tb/tb_spi_master_gen2.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the second-generation SPI master: mode struct, FSM state enum and
// the four standard CPOL/CPHA mode constants.
package spi_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_t;

    localparam spi_mode_t MODE0 = spi_mode_t'(2'b00);
    localparam spi_mode_t MODE1 = spi_mode_t'(2'b01);
    localparam spi_mode_t MODE2 = spi_mode_t'(2'b10);
    localparam spi_mode_t MODE3 = spi_mode_t'(2'b11);

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: while enabled, pulses tick_o once every div_i+1 clk cycles,
// restarting the count on the first enabled cycle.
module spi_clk_gen #(
    parameter int CLKDIV_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    input  logic [CLKDIV_W-1:0] div_i,
    output logic                tick_o
);

    logic [CLKDIV_W-1:0] cnt_q, cnt_d, cnt_cur;
    logic                en_q;

    // On enable rise the count starts from div_i so the first tick lands a full period later.
    always_comb begin
        cnt_cur = (en_i && !en_q) ? div_i : cnt_q;
        tick_o  = en_i && (cnt_cur == '0);
        cnt_d   = '0;
        if (en_i) begin
            cnt_d = (cnt_cur == '0) ? div_i : cnt_cur - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_i;
        end
    end

endmodule

// File: rtl/spi_master_gen2.sv
// Parametrised SPI master (all CPOL/CPHA modes, MSB/LSB first, valid/ready TX, RX strobe).
// Optional: define SPI_MST_LOOPBACK_EN to add a loopback input that samples mosi instead of miso.
module spi_master_gen2
    import spi_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_SS   = 4,
    parameter int CLKDIV_W = 8,
    localparam int SS_IDX_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic                lsb_first,
    input  logic [CLKDIV_W-1:0] clk_div,
    input  logic [SS_IDX_W-1:0] ss_sel,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [DATA_W-1:0]   tx_data,
    output logic                rx_valid,
    output logic [DATA_W-1:0]   rx_data,
    output logic                busy,
`ifdef SPI_MST_LOOPBACK_EN
    input  logic                loopback,
`endif
    output logic                sclk,
    output logic                mosi,
    input  logic                miso,
    output logic [NUM_SS-1:0]   ss_n
);

    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

    spi_state_t          state_q, state_d;
    spi_mode_t           mode_q, mode_d;
    logic                lsb_q, lsb_d;
    logic [CLKDIV_W-1:0] div_q, div_d;
    logic [DATA_W-1:0]   txsh_q, txsh_d, rxsh_q, rxsh_d, rx_data_q, rx_data_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic                sclk_q, sclk_d, mosi_q, mosi_d, rx_valid_q, rx_valid_d;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
    logic                tick, sample_bit, leading;

    function automatic logic [DATA_W-1:0] reverse(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
        return r;
    endfunction

    spi_clk_gen #(.CLKDIV_W(CLKDIV_W)) u_clk_gen (
        .clk    (clk),
        .reset  (reset),
        .en_i   (state_q != IDLE),
        .div_i  (div_q),
        .tick_o (tick)
    );

`ifdef SPI_MST_LOOPBACK_EN
    logic lb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lb_q <= 1'b0;
        end else if (state_q == IDLE && tx_valid) begin
            lb_q <= loopback;
        end
    end

    assign sample_bit = lb_q ? mosi_q : miso;
`else
    assign sample_bit = miso;
`endif

    // Words are stored MSB-aligned (reversed on load for LSB-first) so the shifters only move left.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        lsb_d      = lsb_q;
        div_d      = div_q;
        txsh_d     = txsh_q;
        rxsh_d     = rxsh_q;
        rx_data_d  = rx_data_q;
        edge_d     = edge_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        rx_valid_d = 1'b0;
        leading    = ~edge_q[0];
        case (state_q)
            IDLE: begin
                sclk_d = mode[1];
                if (tx_valid) begin
                    state_d = SETUP;
                    mode_d  = spi_mode_t'(mode);
                    lsb_d   = lsb_first;
                    div_d   = clk_div;
                    txsh_d  = lsb_first ? reverse(tx_data) : tx_data;
                    mosi_d  = mode[0] ? 1'b0 : (lsb_first ? tx_data[0] : tx_data[DATA_W-1]);
                    edge_d  = '0;
                    for (int i = 0; i < NUM_SS; i++) ss_n_d[i] = (ss_sel != SS_IDX_W'(i));
                end
            end
            SETUP, XFER: begin
                if (tick) begin
                    if (edge_q == LAST_EDGE) begin
                        state_d = HOLD;
                    end else begin
                        state_d = XFER;
                        sclk_d  = ~sclk_q;
                        edge_d  = edge_q + 1'b1;
                        if (leading != mode_q.cpha) begin
                            rxsh_d = {rxsh_q[DATA_W-2:0], sample_bit};
                        end else begin
                            mosi_d = mode_q.cpha ? txsh_q[DATA_W-1] : txsh_q[DATA_W-2];
                            txsh_d = {txsh_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d    = GAP;
                    ss_n_d     = '1;
                    mosi_d     = 1'b0;
                    rx_valid_d = 1'b1;
                    rx_data_d  = lsb_q ? reverse(rxsh_q) : rxsh_q;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                    sclk_d  = mode_q.cpol;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= MODE0;
            lsb_q      <= 1'b0;
            div_q      <= '0;
            txsh_q     <= '0;
            rxsh_q     <= '0;
            rx_data_q  <= '0;
            edge_q     <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            lsb_q      <= lsb_d;
            div_q      <= div_d;
            txsh_q     <= txsh_d;
            rxsh_q     <= rxsh_d;
            rx_data_q  <= rx_data_d;
            edge_q     <= edge_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready = (state_q == IDLE) && !reset;
    assign busy     = (state_q != IDLE);
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_gen2.sv
// Scoreboard bench for spi_master_gen2: randomized words against a pin-level SPI slave model,
// with frame timing, bit order, chip-select and abort behaviour checked from the protocol rules.
module tb_spi_master_gen2;

    localparam int DATA_W   = 8;
    localparam int NUM_SS   = 4;
    localparam int CLKDIV_W = 8;
    localparam int LIMIT    = 6000;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [1:0]          mode = 2'b00;
    logic                lsb_first = 1'b0;
    logic [CLKDIV_W-1:0] clk_div = '0;
    logic [1:0]          ss_sel = '0;
    logic                tx_valid = 1'b0;
    logic                tx_ready;
    logic [DATA_W-1:0]   tx_data = '0;
    logic                rx_valid;
    logic [DATA_W-1:0]   rx_data;
    logic                busy;
    logic                sclk;
    logic                mosi;
    logic                miso = 1'b0;
    logic [NUM_SS-1:0]   ss_n;
    logic                lbNext = 1'b0;
`ifdef SPI_MST_LOOPBACK_EN
    logic                loopback = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0] tx;
        logic [DATA_W-1:0] rx;
        logic [NUM_SS-1:0] ssn;
        int                h;
        int                acc;
    } exp_t;

    typedef struct {
        int   acc;
        int   h;
        logic cpol;
    } rdy_t;

    typedef struct {
        logic [DATA_W-1:0] w;
        logic              cpol;
        logic              cpha;
        logic              lsb;
    } slv_t;

    exp_t expQ[$];
    rdy_t readyQ[$];
    slv_t slaveQ[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] capWord = '0;
    logic [NUM_SS-1:0] capSs = '1;

    spi_master_gen2 #(.DATA_W(DATA_W), .NUM_SS(NUM_SS), .CLKDIV_W(CLKDIV_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .lsb_first (lsb_first),
        .clk_div   (clk_div),
        .ss_sel    (ss_sel),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .busy      (busy),
`ifdef SPI_MST_LOOPBACK_EN
        .loopback  (loopback),
`endif
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .ss_n      (ss_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Present one word at a negedge and hold it until accepted; returns one cycle after acceptance.
    task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic [1:0] md, input logic lsb,
                                 input logic [CLKDIV_W-1:0] div, input logic [1:0] sel,
                                 input logic [DATA_W-1:0] sw);
        int n = 0;
        exp_t e;
        rdy_t r;
        slv_t s;
        tx_data = d; mode = md; lsb_first = lsb; clk_div = div; ss_sel = sel; tx_valid = 1'b1;
`ifdef SPI_MST_LOOPBACK_EN
        loopback = lbNext;
`endif
        while (!tx_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            checkOutput("accept_timeout", tx_ready, 1);
            return;
        end
        e.tx = d; e.rx = lbNext ? d : sw; e.ssn = ~(4'b0001 << sel);
        e.h = int'(div) + 1; e.acc = cyc;
        expQ.push_back(e);
        r.acc = cyc; r.h = e.h; r.cpol = md[1];
        readyQ.push_back(r);
        s.w = sw; s.cpol = md[1]; s.cpha = md[0]; s.lsb = lsb;
        slaveQ.push_back(s);
        @(negedge clk);
    endtask

    // Drop tx_valid and scramble every configuration input until the master is ready again.
    task automatic waitIdle();
        int n = 0;
        tx_valid = 1'b0;
        while (!tx_ready && n < LIMIT) begin
            tx_data = DATA_W'($urandom); mode = 2'($urandom); lsb_first = 1'($urandom);
            clk_div = CLKDIV_W'($urandom); ss_sel = 2'($urandom);
            @(negedge clk);
            n++;
        end
        if (!tx_ready) checkOutput("idle_timeout", tx_ready, 1);
    endtask

    // Pin-level slave: drives miso on its shift edges and captures mosi on its sample edges.
    always @(negedge clk) begin
        static logic busyPrev = 1'b0, sclkPrev = 1'b0, inFrame = 1'b0;
        static int   sIdx = 0, cIdx = 0;
        static slv_t s;
        if (busy && !busyPrev && !reset) begin
            inFrame = (slaveQ.size() > 0);
            if (inFrame) s = slaveQ.pop_front();
            sIdx = 0; cIdx = 0; capWord = '0; capSs = ss_n;
            if (inFrame && !s.cpha) begin
                miso = s.lsb ? s.w[0] : s.w[DATA_W-1];
                sIdx = 1;
            end
        end else if (busy && inFrame && sclk != sclkPrev) begin
            if ((sclk != s.cpol) == s.cpha) begin
                if (sIdx < DATA_W) miso = s.lsb ? s.w[sIdx] : s.w[DATA_W-1-sIdx];
                sIdx++;
            end else begin
                if (cIdx < DATA_W) capWord[s.lsb ? cIdx : DATA_W-1-cIdx] = mosi;
                cIdx++;
            end
        end
        if (!busy) inFrame = 1'b0;
        sclkPrev = sclk;
        busyPrev = busy;
    end

    // Monitor: pops an expectation whenever the DUT strobes rx_valid or becomes ready again.
    always @(negedge clk) begin
        static logic rxvPrev = 1'b0, rdyPrev = 1'b0;
        exp_t e;
        rdy_t r;
        if (rx_valid) begin
            checkOutput("rx_valid_pulse", rxvPrev, 0);
            if (expQ.size() == 0) begin
                checkOutput("rx_valid_unexpected", rx_valid, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("rx_data", rx_data, e.rx);
                checkOutput("rx_time", cyc - e.acc, 1 + (2 * DATA_W + 2) * e.h);
                checkOutput("mosi_word", capWord, e.tx);
                checkOutput("ss_n_frame", capSs, e.ssn);
            end
        end
        if (tx_ready && !rdyPrev && readyQ.size() > 0) begin
            r = readyQ.pop_front();
            checkOutput("ready_time", cyc - r.acc, 1 + (2 * DATA_W + 3) * r.h);
            checkOutput("idle_sclk", sclk, r.cpol);
            checkOutput("idle_ss_n", ss_n, 4'hF);
            checkOutput("idle_mosi", mosi, 0);
            checkOutput("idle_busy", busy, 0);
        end
        rxvPrev = rx_valid;
        rdyPrev = tx_ready;
    end

    initial begin
        logic [1:0] md;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_tx_ready", tx_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_tx_ready", tx_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sclk", sclk, 0);
        checkOutput("rst_mosi", mosi, 0);
        checkOutput("rst_ss_n", ss_n, 4'hF);
        checkOutput("rst_rx_valid", rx_valid, 0);
        checkOutput("rst_rx_data", rx_data, 0);

        applyStimulus(8'hA5, 2'b00, 1'b0, 8'd0, 2'd0, 8'h3C);
        waitIdle();
        applyStimulus(8'h81, 2'b11, 1'b1, 8'd0, 2'd1, 8'h0F);
        waitIdle();

        mode = 2'b11;
        repeat (2) @(negedge clk);
        checkOutput("idle_follows_mode_hi", sclk, 1);
        mode = 2'b00;
        repeat (2) @(negedge clk);
        checkOutput("idle_follows_mode_lo", sclk, 0);

        applyStimulus(8'h3C, 2'b10, 1'b0, 8'd3, 2'd3, 8'hC3);
        waitIdle();
        applyStimulus(8'h69, 2'b01, 1'b0, 8'd1, 2'd2, 8'h96);
        waitIdle();

        applyStimulus(8'h12, 2'b00, 1'b0, 8'd0, 2'd0, 8'hE1);
        applyStimulus(8'h34, 2'b11, 1'b1, 8'd1, 2'd1, 8'h2D);
        applyStimulus(8'h56, 2'b01, 1'b0, 8'd2, 2'd3, 8'h78);
        waitIdle();

        applyStimulus(8'hF0, 2'b01, 1'b1, 8'hFF, 2'd3, 8'h0F);
        waitIdle();

`ifdef SPI_MST_LOOPBACK_EN
        lbNext = 1'b1;
        applyStimulus(8'h5A, 2'b00, 1'b0, 8'd0, 2'd0, 8'h00);
        waitIdle();
        lbNext = 1'b0;
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef SPI_MST_LOOPBACK_EN
            lbNext = 1'($urandom);
`endif
            md = 2'($urandom);
            applyStimulus(DATA_W'($urandom), md, 1'($urandom),
                          ($urandom_range(0, 9) == 0) ? CLKDIV_W'(7) : CLKDIV_W'($urandom_range(0, 3)),
                          2'($urandom), DATA_W'($urandom));
            if ($urandom_range(0, 3) != 0) waitIdle();
        end
        waitIdle();
        lbNext = 1'b0;

        applyStimulus(8'hC6, 2'b00, 1'b0, 8'd0, 2'd2, 8'h6C);
        tx_valid = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("abort_ss_before", ss_n, 4'b1011);
        reset = 1'b1;
        expQ.delete();
        readyQ.delete();
        @(negedge clk);
        checkOutput("abort_ss_n", ss_n, 4'hF);
        checkOutput("abort_sclk", sclk, 0);
        checkOutput("abort_mosi", mosi, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_rx_valid", rx_valid, 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        checkOutput("pending_expectations", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
